// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared types for the data-memory responder: machine word type, access size
// encoding and the responder FSM state encoding.
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  // Access size; 2'b11 is reserved and treated as a fault by the responder.
  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } memsize_e;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_e;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational lane logic for byte/half/word accesses.
// Ports:
//   addr_lo     in  : low two address bits (byte offset inside the word)
//   size        in  : access size (MEM_B / MEM_H / MEM_W, 2'b11 reserved)
//   is_unsigned in  : zero-extend byte/half loads instead of sign-extending
//   wdata       in  : right-aligned store data
//   raw         in  : full RAM word at the addressed index
//   byte_en     out : store byte-lane enables
//   wdata_lane  out : store data replicated onto the addressed lanes
//   rdata_ext   out : extracted and extended load data
//   misalign    out : misaligned access or reserved size
// ---------------------------------------------------------------------------
module lsu_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  memsize_e   size,
  input  logic       is_unsigned,
  input  word_t      wdata,
  input  word_t      raw,
  output logic [3:0] byte_en,
  output word_t      wdata_lane,
  output word_t      rdata_ext,
  output logic       misalign
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Pick the addressed byte and half out of the raw word up front so the
  // size decode below only has to deal with extension.
  always_comb begin
    byte_val = raw[7:0];
    case (addr_lo)
      2'd0:    byte_val = raw[7:0];
      2'd1:    byte_val = raw[15:8];
      2'd2:    byte_val = raw[23:16];
      default: byte_val = raw[31:24];
    endcase
    half_val = addr_lo[1] ? raw[31:16] : raw[15:0];
  end

  // Size decode. Store data is replicated across the word so that whichever
  // lanes are enabled already hold the right bytes; no shifter needed.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = '0;
    rdata_ext  = '0;
    misalign   = 1'b0;
    case (size)
      MEM_B: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = is_unsigned ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
      end
      MEM_H: begin
        misalign   = addr_lo[0];
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
      end
      MEM_W: begin
        misalign   = (addr_lo != 2'b00);
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = raw;
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Data-memory responder at the far end of the core's load/store interface.
// One request is outstanding at a time; the access commits once, LATENCY
// cycles after acceptance, and the response is held until handshaken.
// Parameters:
//   DEPTH_WORDS : number of 32-bit words of storage (index = req_addr[31:2])
//   LATENCY     : acceptance-to-response latency, 1..15
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_size            : MEM_B / MEM_H / MEM_W
//   req_unsigned        : zero-extend byte/half loads
//   req_addr, req_wdata : byte address, right-aligned store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : extended load data, 0 for stores and faults
//   rsp_err             : access fault (misaligned, reserved size, range)
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     req_valid,
  output logic     req_ready,
  input  logic     req_we,
  input  memsize_e req_size,
  input  logic     req_unsigned,
  input  word_t    req_addr,
  input  word_t    req_wdata,
  output logic     rsp_valid,
  input  logic     rsp_ready,
  output word_t    rsp_rdata,
  output logic     rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  dmem_state_e state, next_state;
  logic [3:0]  cnt;
  logic        commit;

  logic        cap_we;
  memsize_e    cap_size;
  logic        cap_unsigned;
  word_t       cap_addr;
  word_t       cap_wdata;

  logic        acc_we;
  memsize_e    acc_size;
  logic        acc_unsigned;
  word_t       acc_addr;
  word_t       acc_wdata;
  logic [IDX_W-1:0] ram_idx;
  logic        acc_err;

  logic [3:0]  byte_en;
  word_t       wdata_lane;
  word_t       rdata_ext;
  word_t       raw;
  logic        misalign;

  word_t       mem [DEPTH_WORDS];

  // With LATENCY=1 the access commits on the acceptance edge itself, before
  // the capture registers are loaded, so the commit path reads the live
  // request while idle and the captured copy otherwise.
  always_comb begin
    if (state == DMEM_IDLE) begin
      acc_we       = req_we;
      acc_size     = req_size;
      acc_unsigned = req_unsigned;
      acc_addr     = req_addr;
      acc_wdata    = req_wdata;
    end else begin
      acc_we       = cap_we;
      acc_size     = cap_size;
      acc_unsigned = cap_unsigned;
      acc_addr     = cap_addr;
      acc_wdata    = cap_wdata;
    end
  end

  assign ram_idx = acc_addr[IDX_W+1:2];
  assign raw     = mem[ram_idx];
  assign acc_err = misalign | (acc_addr[31:2] >= DEPTH_LIM);

  lsu_align u_align (
    .addr_lo     (acc_addr[1:0]),
    .size        (acc_size),
    .is_unsigned (acc_unsigned),
    .wdata       (acc_wdata),
    .raw         (raw),
    .byte_en     (byte_en),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  // Next-state logic; also decides the single commit edge of each access.
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    case (state)
      DMEM_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            next_state = DMEM_RESP;
            commit     = 1'b1;
          end else begin
            next_state = DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt == 4'd0) begin
          next_state = DMEM_RESP;
          commit     = 1'b1;
        end
      end
      DMEM_RESP: begin
        if (rsp_ready) begin
          next_state = DMEM_IDLE;
        end
      end
      default: next_state = DMEM_IDLE;
    endcase
  end

  assign req_ready = (state == DMEM_IDLE);
  assign rsp_valid = (state == DMEM_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DMEM_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latency counter and the registered response. The response registers only
  // change on a commit edge, which keeps them stable under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == DMEM_IDLE && req_valid) begin
        cnt <= 4'(LATENCY - 1);
      end else if (state == DMEM_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? '0 : rdata_ext;
      end
    end
  end

  // Request capture; data-only registers, no reset needed.
  always_ff @(posedge clk) begin
    if (state == DMEM_IDLE && req_valid) begin
      cap_we       <= req_we;
      cap_size     <= req_size;
      cap_unsigned <= req_unsigned;
      cap_addr     <= req_addr;
      cap_wdata    <= req_wdata;
    end
  end

  // RAM write port. Reset on the commit edge suppresses the write, so an
  // aborted access never lands in memory. Contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && commit && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[ram_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Two responders share one stimulus bus: dut0 with LATENCY=2 and dut1 with
// LATENCY=1. 'sel' routes req_valid to one of them and picks which outputs
// are observed. A behavioural model tracks each responder's memory and
// expected handshake timing; directed accesses carry hand-computed results.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH = 1024;

  logic     clk = 1'b0;
  logic     reset = 1'b1;
  logic     sel = 1'b0;
  logic     req_valid = 1'b0;
  logic     req_we = 1'b0;
  memsize_e req_size = MEM_W;
  logic     req_unsigned = 1'b0;
  word_t    req_addr = '0;
  word_t    req_wdata = '0;
  logic     rsp_ready = 1'b1;

  logic     rdy0, rdy1, vld0, vld1, err0, err1;
  word_t    rd0, rd1;

  logic     cur_req_ready, cur_rsp_valid, cur_rsp_err;
  word_t    cur_rsp_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid & ~sel),
    .req_ready    (rdy0),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (vld0),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rd0),
    .rsp_err      (err0)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid & sel),
    .req_ready    (rdy1),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (vld1),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rd1),
    .rsp_err      (err1)
  );

  assign cur_req_ready = sel ? rdy1 : rdy0;
  assign cur_rsp_valid = sel ? vld1 : vld0;
  assign cur_rsp_rdata = sel ? rd1 : rd0;
  assign cur_rsp_err   = sel ? err1 : err0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mm0 [int];
  logic [31:0] mm1 [int];

  function automatic logic [31:0] get_word(input logic s, input int idx);
    if (s) return mm1.exists(idx) ? mm1[idx] : 32'h0;
    return mm0.exists(idx) ? mm0[idx] : 32'h0;
  endfunction

  // Edges between acceptance and visible response: the LATENCY=1 responder
  // answers on the acceptance edge itself.
  function automatic int lat_of(input logic s);
    return s ? 0 : 2;
  endfunction

  // Whole access computed arithmetically from address, size and memory.
  function automatic void model_eval(input logic s, input logic we, input logic [1:0] size,
                                     input logic uns, input logic [31:0] addr,
                                     input logic [31:0] wdata, output logic err,
                                     output logic [31:0] rdata, output logic [31:0] nword);
    int nb;
    int off;
    logic [31:0] word, mask, val;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    err = (size == 2'b11) || (addr % nb != 0) || ((addr >> 2) >= DEPTH);
    word = get_word(s, int'(addr >> 2));
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    val  = (word >> (8 * off)) & mask;
    if (!uns && nb < 4 && val[8*nb-1]) val = val | ~mask;
    rdata = (we || err) ? 32'h0 : val;
    nword = word;
    if (!err) begin
      for (int k = 0; k < nb; k++) nword[8*(off+k) +: 8] = wdata[8*k +: 8];
    end
  endfunction

  int          cyc = 0;
  int          commit_cyc = 0;
  int          m_phase = 0;   // 0 idle, 1 waiting, 2 responding
  logic        m_live = 1'b0;
  logic        p_err, p_write, p_sel;
  logic [31:0] p_rdata, p_word;
  int          p_idx;

  // Model update on each edge from the inputs the DUT also samples, then
  // compare the observed responder's outputs just after the edge.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_phase = 0;
      m_live  = 1'b1;
    end else if (m_live) begin
      case (m_phase)
        0: if (req_valid) begin
          model_eval(sel, req_we, req_size, req_unsigned, req_addr, req_wdata,
                     p_err, p_rdata, p_word);
          p_write = req_we && !p_err;
          p_idx   = int'(req_addr >> 2);
          p_sel   = sel;
          if (lat_of(sel) == 0) begin
            if (p_write) begin
              if (p_sel) mm1[p_idx] = p_word; else mm0[p_idx] = p_word;
            end
            m_phase = 2;
          end else begin
            commit_cyc = cyc + lat_of(sel);
            m_phase = 1;
          end
        end
        1: if (cyc == commit_cyc) begin
          if (p_write) begin
            if (p_sel) mm1[p_idx] = p_word; else mm0[p_idx] = p_word;
          end
          m_phase = 2;
        end
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
    #1;
    if (m_live) begin
      checkOutput("cmp.req_ready", {31'b0, cur_req_ready}, {31'b0, m_phase == 0});
      checkOutput("cmp.rsp_valid", {31'b0, cur_rsp_valid}, {31'b0, m_phase == 2});
      if (m_phase == 2) begin
        checkOutput("cmp.rsp_rdata", cur_rsp_rdata, p_rdata);
        checkOutput("cmp.rsp_err", {31'b0, cur_rsp_err}, {31'b0, p_err});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Present one request for a single edge; returns at the negedge after
  // the acceptance edge.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_we       = we;
    req_size     = memsize_e'(size);
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic runAccess(input string name, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
    int k;
    applyStimulus(we, size, uns, addr, wdata);
    k = 0;
    while (!cur_rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!cur_rsp_valid) begin
      checkOutput({name, ".timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({name, ".latency"}, k, lat_of(sel));
      checkOutput({name, ".rdata"}, cur_rsp_rdata, exp_rdata);
      checkOutput({name, ".err"}, {31'b0, cur_rsp_err}, {31'b0, exp_err});
    end
    if (rsp_ready) @(negedge clk);
  endtask

  initial begin
    int k;
    $display("[TB] start");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset.req_ready", {31'b0, cur_req_ready}, 32'd1);
    checkOutput("reset.rsp_valid", {31'b0, cur_rsp_valid}, 32'd0);
    checkOutput("reset.rsp_rdata", cur_rsp_rdata, 32'd0);
    checkOutput("reset.rsp_err", {31'b0, cur_rsp_err}, 32'd0);

    // Word store and read-back
    runAccess("sw10", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    runAccess("lw10", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    // Byte/half extraction and extension
    runAccess("lb11",  0, 2'd0, 0, 32'h11, 32'h0, 32'hFFFFFFBE, 0);
    runAccess("lbu11", 0, 2'd0, 1, 32'h11, 32'h0, 32'h000000BE, 0);
    runAccess("lh12",  0, 2'd1, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
    runAccess("lhu12", 0, 2'd1, 1, 32'h12, 32'h0, 32'h0000DEAD, 0);
    runAccess("lwu10", 0, 2'd2, 1, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    // Partial stores preserve untouched lanes
    runAccess("sb13", 1, 2'd0, 0, 32'h13, 32'h00000012, 32'h0, 0);
    runAccess("sh10", 1, 2'd1, 0, 32'h10, 32'h00005678, 32'h0, 0);
    runAccess("lw10b", 0, 2'd2, 0, 32'h10, 32'h0, 32'h12AD5678, 0);

    // Faults
    runAccess("lw02",  0, 2'd2, 0, 32'h02, 32'h0, 32'h0, 1);
    runAccess("sh11",  1, 2'd1, 0, 32'h11, 32'hFFFF, 32'h0, 1);
    runAccess("rsv",   0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1);
    runAccess("sw0",   1, 2'd2, 0, 32'h0, 32'h55AA55AA, 32'h0, 0);
    runAccess("swoor", 1, 2'd2, 0, DEPTH * 4, 32'hFFFFFFFF, 32'h0, 1);
    runAccess("lw0",   0, 2'd2, 0, 32'h0, 32'h0, 32'h55AA55AA, 0);
    runAccess("lw10c", 0, 2'd2, 0, 32'h10, 32'h0, 32'h12AD5678, 0);

    // Backpressure with an ignored request pulse
    rsp_ready = 1'b0;
    applyStimulus(0, 2'd2, 0, 32'h10, 32'h0);
    k = 0;
    while (!cur_rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput("bp.latency", k, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp.rsp_valid", {31'b0, cur_rsp_valid}, 32'd1);
      checkOutput("bp.rsp_rdata", cur_rsp_rdata, 32'h12AD5678);
      checkOutput("bp.rsp_err", {31'b0, cur_rsp_err}, 32'd0);
      checkOutput("bp.req_ready", {31'b0, cur_req_ready}, 32'd0);
      if (i == 2) begin
        req_we = 1'b1; req_size = MEM_W; req_addr = 32'h10; req_wdata = 32'h0;
        req_valid = 1'b1;
      end
      if (i == 3) req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp.idle_ready", {31'b0, cur_req_ready}, 32'd1);
    checkOutput("bp.idle_valid", {31'b0, cur_rsp_valid}, 32'd0);
    runAccess("bp.lw10", 0, 2'd2, 0, 32'h10, 32'h0, 32'h12AD5678, 0);

    // Reset while waiting aborts the store
    runAccess("sw20", 1, 2'd2, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0);
    applyStimulus(1, 2'd2, 0, 32'h20, 32'h11111111);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.wait.valid", {31'b0, cur_rsp_valid}, 32'd0);
    runAccess("rst.wait.lw20", 0, 2'd2, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0);

    // LATENCY=1: commit on acceptance, reset drops only the response
    sel = 1'b1;
    runAccess("l1.sw20", 1, 2'd2, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0);
    runAccess("l1.lb23", 0, 2'd0, 0, 32'h23, 32'h0, 32'hFFFFFFCA, 0);
    rsp_ready = 1'b0;
    applyStimulus(1, 2'd2, 0, 32'h20, 32'h11111111);
    checkOutput("l1.resp_valid", {31'b0, cur_rsp_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    checkOutput("l1.dropped", {31'b0, cur_rsp_valid}, 32'd0);
    runAccess("l1.lw20", 0, 2'd2, 0, 32'h20, 32'h0, 32'h11111111, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
